// File: rtl/ex_stage_if.sv
// ID/EX operand bundle, WB bypass and EX/MEM result bundle around the execute stage.
// Upstream/bench drives through master; the execute stage sits on slave.
interface ex_stage_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int FUNC_W = 5
);
  logic [REG_AW-1:0] rd_in;
  logic [REG_AW-1:0] rt_in;
  logic [REG_AW-1:0] rs_in;
  logic [FUNC_W-1:0] func_in;
  logic [DATA_W-1:0] rs_data_in;
  logic [DATA_W-1:0] rt_data_in;
  logic [DATA_W-1:0] imm_in;
  logic              wb_we;
  logic [REG_AW-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              hold;
  logic              flush;
  logic              ex_busy;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] store_out;
  logic [REG_AW-1:0] dst_out;
  logic              reg_we_out;
  logic              mem_re_out;
  logic              mem_we_out;
  logic              z_flag;
  logic              c_flag;

  modport master (
    output rd_in, rt_in, rs_in, func_in, rs_data_in, rt_data_in, imm_in,
    output wb_we, wb_dst, wb_data, hold, flush,
    input  ex_busy, alu_out, store_out, dst_out, reg_we_out, mem_re_out, mem_we_out,
    input  z_flag, c_flag
  );

  modport slave (
    input  rd_in, rt_in, rs_in, func_in, rs_data_in, rt_data_in, imm_in,
    input  wb_we, wb_dst, wb_data, hold, flush,
    output ex_busy, alu_out, store_out, dst_out, reg_we_out, mem_re_out, mem_we_out,
    output z_flag, c_flag
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, 8-step shift-add MUL into the EX/MEM register.
// 1 cycle for ALU ops, 9 for MUL; ex_busy stalls ID/EX during MUL or hold.
module ex_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int FUNC_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(3);
  localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(4);
  localparam logic [FUNC_W-1:0] F_XOR  = FUNC_W'(5);
  localparam logic [FUNC_W-1:0] F_ADDI = FUNC_W'(7);
  localparam logic [FUNC_W-1:0] F_LW   = FUNC_W'(8);
  localparam logic [FUNC_W-1:0] F_SW   = FUNC_W'(9);
  localparam logic [FUNC_W-1:0] F_MUL  = FUNC_W'(10);
  localparam logic [FUNC_W-1:0] F_SHL  = FUNC_W'(11);
  localparam logic [FUNC_W-1:0] F_SHR  = FUNC_W'(12);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0] alu_q, store_q;
  logic [REG_AW-1:0] dst_q;
  logic              we_q, re_q, mwe_q, z_q, c_q;

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mcand, mplier, acc, acc_next;
  logic [REG_AW-1:0] mul_rd;

  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              exmem_fwd_ok;

  // Loads are excluded from EX/MEM bypass: their alu_out is an address, not data.
  assign exmem_fwd_ok = we_q & ~re_q;

  always_comb begin
    rs_fwd = bus.rs_data_in;
    if (exmem_fwd_ok && dst_q == bus.rs_in)            rs_fwd = alu_q;
    else if (bus.wb_we && bus.wb_dst == bus.rs_in)     rs_fwd = bus.wb_data;
    rt_fwd = bus.rt_data_in;
    if (exmem_fwd_ok && dst_q == bus.rt_in)            rt_fwd = alu_q;
    else if (bus.wb_we && bus.wb_dst == bus.rt_in)     rt_fwd = bus.wb_data;
  end

  // Single-cycle decode
  logic [DATA_W-1:0] res;
  logic              carry, wr_c, wr_z, d_we, d_re, d_mwe, is_mul;
  logic [REG_AW-1:0] d_dst;

  always_comb begin
    res    = '0;
    carry  = 1'b0;
    wr_c   = 1'b0;
    wr_z   = 1'b0;
    d_we   = 1'b0;
    d_re   = 1'b0;
    d_mwe  = 1'b0;
    is_mul = 1'b0;
    d_dst  = bus.rd_in;
    case (bus.func_in)
      F_ADD:  begin {carry, res} = {1'b0, rs_fwd} + {1'b0, rt_fwd}; wr_c = 1'b1; wr_z = 1'b1; d_we = 1'b1; end
      F_SUB:  begin {carry, res} = {1'b0, rs_fwd} - {1'b0, rt_fwd}; wr_c = 1'b1; wr_z = 1'b1; d_we = 1'b1; end
      F_AND:  begin res = rs_fwd & rt_fwd; wr_z = 1'b1; d_we = 1'b1; end
      F_OR:   begin res = rs_fwd | rt_fwd; wr_z = 1'b1; d_we = 1'b1; end
      F_XOR:  begin res = rs_fwd ^ rt_fwd; wr_z = 1'b1; d_we = 1'b1; end
      F_ADDI: begin
        {carry, res} = {1'b0, rs_fwd} + {1'b0, bus.imm_in};
        wr_c = 1'b1; wr_z = 1'b1; d_we = 1'b1; d_dst = bus.rt_in;
      end
      F_LW:   begin res = rs_fwd + bus.imm_in; d_we = 1'b1; d_re = 1'b1; d_dst = bus.rt_in; end
      F_SW:   begin res = rs_fwd + bus.imm_in; d_mwe = 1'b1; d_dst = bus.rt_in; end
      F_MUL:  is_mul = 1'b1;
      F_SHL:  begin res = rs_fwd << rt_fwd[2:0]; wr_z = 1'b1; d_we = 1'b1; end
      F_SHR:  begin res = rs_fwd >> rt_fwd[2:0]; wr_z = 1'b1; d_we = 1'b1; end
      default: ;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // FSM next state and stall
  logic busy, mul_start;

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    mul_start = 1'b0;
    if (bus.hold) begin
      busy = 1'b1;
    end else begin
      case (state)
        IDLE: if (is_mul && !bus.flush) begin
          state_n   = RUN;
          busy      = 1'b1;
          mul_start = 1'b1;
        end
        RUN: begin
          if (bus.flush || cnt == CNT_LAST) state_n = IDLE;
          else                              busy    = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Next EX/MEM contents; anything not explicitly written is a bubble.
  logic [DATA_W-1:0] n_alu, n_store;
  logic [REG_AW-1:0] n_dst;
  logic              n_we, n_re, n_mwe, n_z, n_c;

  always_comb begin
    n_alu   = '0;
    n_store = '0;
    n_dst   = '0;
    n_we    = 1'b0;
    n_re    = 1'b0;
    n_mwe   = 1'b0;
    n_z     = z_q;
    n_c     = c_q;
    if (state == RUN) begin
      if (!bus.flush && cnt == CNT_LAST) begin
        n_alu = acc_next;
        n_dst = mul_rd;
        n_we  = 1'b1;
        n_z   = (acc_next == '0);
      end
    end else if (!bus.flush && (d_we || d_mwe)) begin
      n_alu   = res;
      n_store = rt_fwd;
      n_dst   = d_dst;
      n_we    = d_we;
      n_re    = d_re;
      n_mwe   = d_mwe;
      if (wr_z) n_z = (res == '0);
      if (wr_c) n_c = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      store_q <= '0;
      dst_q   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      mwe_q   <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mul_rd  <= '0;
    end else if (!bus.hold) begin
      alu_q   <= n_alu;
      store_q <= n_store;
      dst_q   <= n_dst;
      we_q    <= n_we;
      re_q    <= n_re;
      mwe_q   <= n_mwe;
      z_q     <= n_z;
      c_q     <= n_c;
      if (mul_start) begin
        mcand  <= rs_fwd;
        mplier <= rt_fwd;
        acc    <= '0;
        cnt    <= '0;
        mul_rd <= bus.rd_in;
      end else if (state == RUN) begin
        if (bus.flush) begin
          cnt <= '0;
        end else begin
          cnt    <= cnt + 1'b1;
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
      end
    end
  end

  assign bus.ex_busy    = busy;
  assign bus.alu_out    = alu_q;
  assign bus.store_out  = store_q;
  assign bus.dst_out    = dst_q;
  assign bus.reg_we_out = we_q;
  assign bus.mem_re_out = re_q;
  assign bus.mem_we_out = mwe_q;
  assign bus.z_flag     = z_q;
  assign bus.c_flag     = c_q;
endmodule
